// File: rtl/sr_pulse_driver_if.sv
// ---------------------------------------------------------------------------
// sr_pulse_driver_if
//   Bundles the command handshake, the SR drive lines, the cell feedback and
//   the status outputs of sr_pulse_driver.
//
//   Signals
//     req_valid  command valid                      (master -> slave)
//     req_value  1 = set cell, 0 = reset cell       (master -> slave)
//     req_ready  driver idle, can accept a command  (slave  -> master)
//     s, r       set / reset drive to the SR cell   (slave  -> master)
//     q_fb       cell q, asynchronous               (master -> slave)
//     qbar_fb    cell qbar, asynchronous            (master -> slave)
//     done       one-cycle completion pulse         (slave  -> master)
//     err        readback failed, valid with done   (slave  -> master)
//     busy       command in progress                (slave  -> master)
//     err_cnt    saturating failed-command count    (slave  -> master)
//
//   Modports
//     slave  : the pulse driver itself
//     master : control logic plus the storage cell
// ---------------------------------------------------------------------------
interface sr_pulse_driver_if;
    logic       req_valid;
    logic       req_value;
    logic       req_ready;
    logic       s;
    logic       r;
    logic       q_fb;
    logic       qbar_fb;
    logic       done;
    logic       err;
    logic       busy;
    logic [7:0] err_cnt;

    modport slave (
        input  req_valid, req_value, q_fb, qbar_fb,
        output req_ready, s, r, done, err, busy, err_cnt
    );

    modport master (
        output req_valid, req_value, q_fb, qbar_fb,
        input  req_ready, s, r, done, err, busy, err_cnt
    );
endinterface

// File: rtl/sr_pulse_driver.sv
// ---------------------------------------------------------------------------
// sr_pulse_driver
//   Command-side driver for an external SR storage cell. A requested bit is
//   accepted over a valid/ready handshake, the cell is driven with a timed
//   set (s) or reset (r) pulse, both lines are held low for a dead time, and
//   then the synchronised q/qbar feedback is checked until it matches or a
//   timeout expires. Completion is reported with a one-cycle done pulse and
//   an err flag; failures are counted in a saturating 8-bit counter.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    sr_pulse_driver_if.slave (handshake, s/r drive, feedback, status)
//
//   Parameters
//     PULSE_W  cycles s (or r) is high per command, >= 1
//     DEAD_T   cycles s=r=0 between pulse and readback, 0 = skip
//     CHK_TMO  maximum readback cycles before declaring failure, >= 1
// ---------------------------------------------------------------------------
module sr_pulse_driver #(
    parameter int PULSE_W = 4,
    parameter int DEAD_T  = 2,
    parameter int CHK_TMO = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    sr_pulse_driver_if.slave   bus
);

    // One shared phase counter sized for the longest phase.
    localparam int MAX_PH = (PULSE_W > DEAD_T)
                          ? ((PULSE_W > CHK_TMO) ? PULSE_W : CHK_TMO)
                          : ((DEAD_T  > CHK_TMO) ? DEAD_T  : CHK_TMO);
    localparam int CW = $clog2(MAX_PH + 1);

    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_T - 1);
    localparam logic [CW-1:0] CHK_LAST   = CW'(CHK_TMO - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_DEAD  = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          val_q, val_d;
    logic          s_q, s_d;
    logic          r_q, r_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    // -----------------------------------------------------------------------
    // Feedback synchronisers: bit 0 = q, bit 1 = qbar.
    // -----------------------------------------------------------------------
    logic [1:0] fb_raw;
    logic [1:0] fb_sync;

    assign fb_raw = {bus.qbar_fb, bus.q_fb};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic [1:0] stage_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_q <= 2'b00;
                end else begin
                    stage_q <= {stage_q[0], fb_raw[gi]};
                end
            end
            assign fb_sync[gi] = stage_q[1];
        end
    endgenerate

    logic q_s, qb_s;
    assign q_s  = fb_sync[0];
    assign qb_s = fb_sync[1];

    // Requiring qb_s to be the complement of q_s makes the illegal q==qbar
    // state a mismatch.
    logic match;
    assign match = (q_s == val_q) && (qb_s == ~val_q);

    // ready_q is the registered form of "state is IDLE", so it is low while
    // reset is asserted and rises on the first edge after release.
    logic accept;
    assign accept = bus.req_valid && ready_q;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        val_d     = val_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    val_d   = bus.req_value;
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = (DEAD_T == 0) ? ST_CHECK : ST_DEAD;
                end
            end
            ST_DEAD: begin
                if (cnt_q == DEAD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (match) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (cnt_q == CHK_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with
        // the state they describe. s and r are derived from one bit and its
        // complement, both gated by PULSE, so they can never be high together.
        s_d     = (state_d == ST_PULSE) &&  val_d;
        r_d     = (state_d == ST_PULSE) && !val_d;
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            val_q     <= 1'b0;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            val_q     <= val_d;
            s_q       <= s_d;
            r_q       <= r_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.s         = s_q;
    assign bus.r         = r_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.req_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// ---------------------------------------------------------------------------
// tb_sr_pulse_driver
//   Directed bench for sr_pulse_driver with default parameters. A behavioural
//   SR cell model closes the loop from s/r back to q_fb/qbar_fb; fb_mode can
//   override the feedback to force readback failures.
//   Cycle numbering: the accept edge is cycle 0; values are observed on the
//   falling edge, and the falling edge after rising edge k is cycle k+1.
// ---------------------------------------------------------------------------
module tb_sr_pulse_driver;

    logic clk;
    logic rst_n;

    sr_pulse_driver_if ifc ();

    sr_pulse_driver #(
        .PULSE_W (4),
        .DEAD_T  (2),
        .CHK_TMO (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared;
    int mismatched;
    int overlap_cnt;

    // Behavioural SR cell: s sets, r resets, neither holds.
    logic cell_q;
    logic cell_qb;
    initial begin
        cell_q  = 1'b0;
        cell_qb = 1'b1;
    end
    always @(ifc.s or ifc.r) begin
        if (ifc.s && !ifc.r) begin
            cell_q  = 1'b1;
            cell_qb = 1'b0;
        end else if (ifc.r && !ifc.s) begin
            cell_q  = 1'b0;
            cell_qb = 1'b1;
        end
    end

    // 0 = cell model, 1 = q stuck at 0, 2 = q and qbar both 1.
    int fb_mode;
    always_comb begin
        ifc.q_fb    = cell_q;
        ifc.qbar_fb = cell_qb;
        if (fb_mode == 1) begin
            ifc.q_fb = 1'b0;
        end else if (fb_mode == 2) begin
            ifc.q_fb    = 1'b1;
            ifc.qbar_fb = 1'b1;
        end
    end

    always @(ifc.s or ifc.r) begin
        if (ifc.s && ifc.r) overlap_cnt++;
    end

    // Issue one command and record s/r per cycle until done (bounded).
    // done_at = -1 if done never arrived.
    task automatic run_cmd(input logic v, output int done_at, output logic err_at,
                           output logic [31:0] s_hist, output logic [31:0] r_hist);
        done_at = -1;
        err_at  = 1'b0;
        s_hist  = '0;
        r_hist  = '0;
        @(negedge clk);
        ifc.req_valid = 1'b1;
        ifc.req_value = v;
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) ifc.req_valid = 1'b0;
            if (k < 31) begin
                s_hist[k+1] = ifc.s;
                r_hist[k+1] = ifc.r;
            end
            if (ifc.done) begin
                done_at = k + 1;
                err_at  = ifc.err;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        // Start a set command and reset in the middle of the pulse.
        @(negedge clk);
        ifc.req_valid = 1'b1;
        ifc.req_value = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.req_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (ifc.s !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_pre_s: got %b want 1", ifc.s);
        end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (ifc.s !== 1'b0 || ifc.r !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_sr_drop: got s=%b r=%b want 0/0", ifc.s, ifc.r);
        end
        compared++;
        if (ifc.err_cnt !== 8'd0 || ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_status: got err_cnt=%0d busy=%b done=%b want 0/0/0",
                     ifc.err_cnt, ifc.busy, ifc.done);
        end
        compared++;
        if (ifc.req_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_ready_in_rst: got %b want 0", ifc.req_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if (ifc.req_ready !== 1'b1 || ifc.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_release: got ready=%b busy=%b want 1/0", ifc.req_ready, ifc.busy);
        end
        $display("reset mid-pulse: s=%b r=%b ready=%b busy=%b", ifc.s, ifc.r, ifc.req_ready, ifc.busy);
    endtask

    task automatic test_set();
        int d; logic e; logic [31:0] sh, rh;
        fb_mode = 0;
        run_cmd(1'b1, d, e, sh, rh);
        compared++;
        if (sh !== 32'h0000_001E || rh !== 32'h0) begin
            mismatched++;
            $display("FAIL set_pulse: got s=%h r=%h want 1e/0", sh, rh);
        end
        compared++;
        if (d !== 8 || e !== 1'b0) begin
            mismatched++;
            $display("FAIL set_done: got cycle=%0d err=%b want 8/0", d, e);
        end
        compared++;
        if (cell_q !== 1'b1 || cell_qb !== 1'b0) begin
            mismatched++;
            $display("FAIL set_cell: got q=%b qb=%b want 1/0", cell_q, cell_qb);
        end
        $display("set cmd: done@%0d err=%b s_hist=%h q=%b", d, e, sh, cell_q);
    endtask

    task automatic test_reset_cmd();
        int d; logic e; logic [31:0] sh, rh;
        fb_mode = 0;
        run_cmd(1'b0, d, e, sh, rh);
        compared++;
        if (rh !== 32'h0000_001E || sh !== 32'h0) begin
            mismatched++;
            $display("FAIL rst_pulse: got s=%h r=%h want 0/1e", sh, rh);
        end
        compared++;
        if (d !== 8 || e !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_done: got cycle=%0d err=%b want 8/0", d, e);
        end
        compared++;
        if (cell_q !== 1'b0 || cell_qb !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_cell: got q=%b qb=%b want 0/1", cell_q, cell_qb);
        end
        $display("reset cmd: done@%0d err=%b r_hist=%h q=%b", d, e, rh, cell_q);
    endtask

    task automatic test_timeout();
        int d; logic e; logic [31:0] sh, rh;
        fb_mode = 1;
        run_cmd(1'b1, d, e, sh, rh);
        compared++;
        if (d !== 15 || e !== 1'b1) begin
            mismatched++;
            $display("FAIL tmo_stuck: got cycle=%0d err=%b want 15/1", d, e);
        end
        compared++;
        if (ifc.err_cnt !== 8'd1) begin
            mismatched++;
            $display("FAIL tmo_cnt1: got %0d want 1", ifc.err_cnt);
        end
        $display("stuck q: done@%0d err=%b err_cnt=%0d", d, e, ifc.err_cnt);
        fb_mode = 2;
        run_cmd(1'b1, d, e, sh, rh);
        compared++;
        if (d !== 15 || e !== 1'b1) begin
            mismatched++;
            $display("FAIL tmo_illegal: got cycle=%0d err=%b want 15/1", d, e);
        end
        compared++;
        if (ifc.err_cnt !== 8'd2) begin
            mismatched++;
            $display("FAIL tmo_cnt2: got %0d want 2", ifc.err_cnt);
        end
        $display("q=qbar=1: done@%0d err=%b err_cnt=%0d", d, e, ifc.err_cnt);
        fb_mode = 0;
    endtask

    task automatic test_back_to_back();
        int accepts, dones;
        int done_cyc [3];
        logic done_err [3];
        logic rdy;
        logic acc;
        fb_mode = 0;
        accepts = 0;
        dones   = 0;
        @(negedge clk);
        ifc.req_valid = 1'b1;
        ifc.req_value = 1'b1;
        rdy = ifc.req_ready;
        for (int k = 0; k < 60 && dones < 3; k++) begin
            @(posedge clk);
            acc = rdy && ifc.req_valid;
            @(negedge clk);
            if (acc) begin
                accepts++;
                if (accepts == 1) ifc.req_value = 1'b0;
                else if (accepts == 2) ifc.req_value = 1'b1;
                else ifc.req_valid = 1'b0;
            end
            if (ifc.done) begin
                done_cyc[dones]  = k + 1;
                done_err[dones]  = ifc.err;
                dones++;
            end
            rdy = ifc.req_ready;
        end
        ifc.req_valid = 1'b0;
        compared++;
        if (dones !== 3 || accepts !== 3) begin
            mismatched++;
            $display("FAIL b2b_count: got dones=%0d accepts=%0d want 3/3", dones, accepts);
        end else begin
            for (int i = 0; i < 3; i++) begin
                compared++;
                if (done_cyc[i] !== 8 * (i + 1) || done_err[i] !== 1'b0) begin
                    mismatched++;
                    $display("FAIL b2b_done%0d: got cycle=%0d err=%b want %0d/0",
                             i, done_cyc[i], done_err[i], 8 * (i + 1));
                end
                $display("b2b done %0d at cycle %0d err=%b", i, done_cyc[i], done_err[i]);
            end
        end
        compared++;
        if (cell_q !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_cell: got q=%b want 1", cell_q);
        end
    endtask

    task automatic test_saturate();
        int d; logic e; logic [31:0] sh, rh;
        fb_mode = 1;
        for (int i = 0; i < 260; i++) begin
            run_cmd(1'b1, d, e, sh, rh);
            if (i == 252) begin
                compared++;
                if (ifc.err_cnt !== 8'd255) begin
                    mismatched++;
                    $display("FAIL sat_reach: got %0d want 255", ifc.err_cnt);
                end
                $display("saturate: after %0d fails err_cnt=%0d", i + 3, ifc.err_cnt);
            end
        end
        compared++;
        if (ifc.err_cnt !== 8'd255 || e !== 1'b1 || d !== 15) begin
            mismatched++;
            $display("FAIL sat_hold: got cnt=%0d err=%b cycle=%0d want 255/1/15", ifc.err_cnt, e, d);
        end
        $display("saturate: final err_cnt=%0d", ifc.err_cnt);
        fb_mode = 0;
    endtask

    task automatic test_no_overlap();
        compared++;
        if (overlap_cnt !== 0) begin
            mismatched++;
            $display("FAIL sr_overlap: got %0d events want 0", overlap_cnt);
        end
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        overlap_cnt   = 0;
        fb_mode       = 0;
        rst_n         = 1'b0;
        ifc.req_valid = 1'b0;
        ifc.req_value = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if (ifc.req_ready !== 1'b1 || ifc.busy !== 1'b0 || ifc.s !== 1'b0 ||
            ifc.r !== 1'b0 || ifc.err_cnt !== 8'd0) begin
            mismatched++;
            $display("FAIL init_state: got ready=%b busy=%b s=%b r=%b cnt=%0d want 1/0/0/0/0",
                     ifc.req_ready, ifc.busy, ifc.s, ifc.r, ifc.err_cnt);
        end
        test_reset();
        test_set();
        test_reset_cmd();
        test_timeout();
        test_back_to_back();
        test_saturate();
        test_no_overlap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
